// File: rtl/decomp_frontend.sv
// Receive-side decompressor front end: plain frames pass straight through, compressed
// frames forward their header and then expand bitmap-packed groups into 256-bit beats.
module decomp_frontend #(
  parameter int HDR_BEATS = 3,
  parameter int N_GROUPS  = 47
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [255:0] axis_tdata,
  input  logic [31:0]  axis_tkeep,
  input  logic         axis_tvalid,
  input  logic         axis_tlast,
  output logic         axis_tready,
  input  logic         axis_comp,
  output logic [255:0] dma_tdata,
  output logic [31:0]  dma_tkeep,
  output logic         dma_tvalid,
  output logic         dma_tlast,
  input  logic         dma_tready,
  output logic         trunc_err
);

  localparam int GW = $clog2(N_GROUPS + 1);
  localparam int HW = $clog2(HDR_BEATS + 2);

  typedef enum logic [2:0] {IDLE, BYPASS, HEADER, FILL, LEN, EXPAND, DRAIN} state_t;
  state_t state_reg, state_next;

  logic [527:0]  buf_reg;
  logic [9:0]    fill_reg;
  logic [GW-1:0] grp_reg;
  logic [HW-1:0] hdr_reg;
  logic          exh_reg;
  logic          run_reg;
  logic [8:0]    glen_reg;
  logic [8:0]    off_reg [8];

  logic [8:0]    off_c [8];
  logic [8:0]    glen_c;
  logic [255:0]  expand_c;
  logic [9:0]    fill_nx;
  logic [9:0]    fill_sh;
  logic          exh_nx;
  logic          out_free;
  logic          in_fire;
  logic          last_grp;
  logic          pass_load;
  logic          fill_load;
  logic          expand_go;

  assign out_free = ~dma_tvalid | dma_tready;
  assign in_fire  = axis_tvalid & axis_tready;
  assign last_grp = (grp_reg == GW'(N_GROUPS - 1));
  assign fill_nx  = in_fire ? fill_reg + 10'd256 : fill_reg;
  assign exh_nx   = exh_reg | (in_fire & axis_tlast);
  assign fill_sh  = (fill_reg > {1'b0, glen_reg}) ? fill_reg - {1'b0, glen_reg} : 10'd0;

  // Payload offsets are a prefix sum of the per-word lengths, starting past the bitmap.
  always_comb begin
    logic [8:0] acc;
    acc = 9'd16;
    for (int w = 0; w < 8; w++) begin
      off_c[w] = acc;
      case (buf_reg[2*w +: 2])
        2'b01:   acc = acc + 9'd8;
        2'b10:   acc = acc + 9'd16;
        2'b11:   acc = acc + 9'd32;
        default: acc = acc;
      endcase
    end
    glen_c = acc;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      logic [1:0]  code;
      logic [31:0] raw;
      assign code = buf_reg[2*gi +: 2];
      assign raw  = buf_reg[off_reg[gi] +: 32];
      assign expand_c[32*gi +: 32] = (code == 2'b11) ? raw :
                                     (code == 2'b10) ? {16'h0, raw[15:0]} :
                                     (code == 2'b01) ? {24'h0, raw[7:0]} : 32'h0;
    end
  endgenerate

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_fire) begin
        if (!axis_comp)     state_next = axis_tlast ? IDLE : BYPASS;
        else if (axis_tlast) state_next = IDLE;
        else                 state_next = (HDR_BEATS == 0) ? FILL : HEADER;
      end
      BYPASS: if (in_fire && axis_tlast) state_next = IDLE;
      HEADER: if (in_fire) begin
        if (axis_tlast)                      state_next = IDLE;
        else if (hdr_reg == HW'(HDR_BEATS))  state_next = FILL;
      end
      FILL: if (fill_nx >= 10'd16 || exh_nx) state_next = LEN;
      LEN: state_next = (fill_reg < {1'b0, glen_c} && !exh_reg) ? FILL : EXPAND;
      EXPAND: if (out_free) begin
        if (last_grp)                 state_next = exh_reg ? IDLE : DRAIN;
        else if (fill_sh >= 10'd16)   state_next = LEN;
        else                          state_next = FILL;
      end
      DRAIN: if (in_fire && axis_tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    axis_tready = 1'b0;
    case (state_reg)
      IDLE, BYPASS, HEADER: axis_tready = run_reg & out_free;
      FILL:                 axis_tready = (fill_reg <= 10'd272) & ~exh_reg;
      DRAIN:                axis_tready = 1'b1;
      default:              axis_tready = 1'b0;
    endcase
    pass_load = in_fire & (state_reg == IDLE || state_reg == BYPASS || state_reg == HEADER);
    fill_load = in_fire & (state_reg == FILL);
    expand_go = out_free & (state_reg == EXPAND);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_reg    <= 1'b0;
      dma_tdata  <= '0;
      dma_tkeep  <= '0;
      dma_tvalid <= 1'b0;
      dma_tlast  <= 1'b0;
      trunc_err  <= 1'b0;
      buf_reg    <= '0;
      fill_reg   <= '0;
      grp_reg    <= '0;
      hdr_reg    <= '0;
      exh_reg    <= 1'b0;
      glen_reg   <= '0;
      for (int w = 0; w < 8; w++) off_reg[w] <= '0;
    end else begin
      run_reg <= 1'b1;
      if (pass_load) begin
        dma_tdata  <= axis_tdata;
        dma_tkeep  <= axis_tkeep;
        dma_tlast  <= axis_tlast;
        dma_tvalid <= 1'b1;
      end else if (expand_go) begin
        dma_tdata  <= expand_c;
        dma_tkeep  <= '1;
        dma_tlast  <= last_grp;
        dma_tvalid <= 1'b1;
      end else if (dma_tready) begin
        dma_tvalid <= 1'b0;
      end

      if (state_reg == IDLE && in_fire) begin
        buf_reg  <= '0;
        fill_reg <= '0;
        grp_reg  <= '0;
        exh_reg  <= 1'b0;
        hdr_reg  <= HW'(1);
        if (axis_comp) trunc_err <= 1'b0;
      end
      if (state_reg == HEADER && in_fire) hdr_reg <= hdr_reg + 1'b1;

      // Bits above fill are always zero, so new beats can simply be ORed in.
      if (fill_load) begin
        buf_reg  <= buf_reg | ({272'b0, axis_tdata} << fill_reg);
        fill_reg <= fill_reg + 10'd256;
        if (axis_tlast) exh_reg <= 1'b1;
      end

      if (state_reg == LEN) begin
        glen_reg <= glen_c;
        for (int w = 0; w < 8; w++) off_reg[w] <= off_c[w];
        if (fill_reg < {1'b0, glen_c} && exh_reg) trunc_err <= 1'b1;
      end

      if (expand_go) begin
        buf_reg  <= buf_reg >> glen_reg;
        fill_reg <= fill_sh;
        grp_reg  <= grp_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decomp_frontend.sv
// Scoreboard bench for decomp_frontend: directed frames push expected beats into a queue,
// an independent monitor pops and compares every DMA transfer.
module tb_decomp_frontend;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [255:0] axis_tdata = '0;
  logic [31:0]  axis_tkeep = '0;
  logic         axis_tvalid = 1'b0;
  logic         axis_tlast = 1'b0;
  logic         axis_tready;
  logic         axis_comp = 1'b0;
  logic [255:0] dma_tdata;
  logic [31:0]  dma_tkeep;
  logic         dma_tvalid;
  logic         dma_tlast;
  logic         dma_tready;
  logic         trunc_err;

  always #5 aclk = ~aclk;

  decomp_frontend dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_tdata(axis_tdata), .axis_tkeep(axis_tkeep), .axis_tvalid(axis_tvalid),
    .axis_tlast(axis_tlast), .axis_tready(axis_tready), .axis_comp(axis_comp),
    .dma_tdata(dma_tdata), .dma_tkeep(dma_tkeep), .dma_tvalid(dma_tvalid),
    .dma_tlast(dma_tlast), .dma_tready(dma_tready), .trunc_err(trunc_err)
  );

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
  } beat_t;

  beat_t          exp_q[$];
  logic [255:0]   grp_exp[$];
  int             n_vec = 0;
  int             n_err = 0;
  bit             mon_en = 1'b1;
  bit             bp_mode = 1'b0;
  logic [12799:0] body_bits;
  int             body_pos;
  logic [255:0]   hdr_d [4];
  logic [31:0]    hdr_k [4];
  logic [127:0]   mix_q;

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic rnd_bit();
    return ($urandom_range(0, 1) != 0);
  endfunction

  task automatic append(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) body_bits[body_pos + i] = v[i];
    body_pos += n;
  endtask

  // Bit-level packer: emits bitmap then payloads, and records the expanded beat.
  task automatic add_group(input logic [15:0] bm, input logic [255:0] words);
    logic [255:0] e;
    logic [31:0]  w;
    append({16'h0, bm}, 16);
    for (int i = 0; i < 8; i++) begin
      w = words[32*i +: 32];
      case (bm[2*i +: 2])
        2'b00: e[32*i +: 32] = 32'h0;
        2'b01: begin append(w, 8);  e[32*i +: 32] = {24'h0, w[7:0]};  end
        2'b10: begin append(w, 16); e[32*i +: 32] = {16'h0, w[15:0]}; end
        default: begin append(w, 32); e[32*i +: 32] = w; end
      endcase
    end
    grp_exp.push_back(e);
  endtask

  task automatic start_frame();
    body_bits = '0;
    body_pos  = 0;
    grp_exp.delete();
    for (int i = 0; i < 4; i++) begin
      hdr_d[i] = rand256();
      hdr_k[i] = $urandom;
    end
  endtask

  task automatic push_comp();
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.data = hdr_d[i]; b.keep = hdr_k[i]; b.last = 1'b0;
      exp_q.push_back(b);
    end
    for (int g = 0; g < 47; g++) begin
      b.data = (g < grp_exp.size()) ? grp_exp[g] : 256'h0;
      b.keep = 32'hFFFF_FFFF;
      b.last = (g == 46);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l, input logic c);
    int t;
    t = 0;
    axis_tdata = d; axis_tkeep = k; axis_tlast = l; axis_comp = c; axis_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (axis_tready) break;
      t++;
      if (t > 2000) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout: got axis_tready=0 for 2000 cycles, required acceptance");
        finish_run();
      end
    end
    @(posedge aclk);
    #1;
    axis_tvalid = 1'b0;
  endtask

  task automatic send_comp(input int extra, input int max_body);
    int nb;
    logic [255:0] d;
    nb = (body_pos + 255) / 256;
    for (int i = 0; i < 4; i++) send_beat(hdr_d[i], hdr_k[i], 1'b0, (i == 0) ? 1'b1 : rnd_bit());
    for (int i = 0; i < nb + extra && i < max_body; i++) begin
      d = (i < nb) ? body_bits[256*i +: 256] : rand256();
      send_beat(d, 32'h0, (i == nb + extra - 1), rnd_bit());
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge aclk);
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d beats still pending, required 0", exp_q.size());
      finish_run();
    end
    repeat (6) @(posedge aclk);
    #1;
  endtask

  // DMA ready: always 1, or toggling every cycle in backpressure mode.
  initial begin
    dma_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      dma_tready = bp_mode ? ~dma_tready : 1'b1;
    end
  end

  // Monitor: pops one expected beat per DMA transfer; also checks hold-while-stalled.
  initial begin
    beat_t        e;
    logic         stall_prev;
    logic [255:0] held;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge aclk);
      if (mon_en && aresetn) begin
        if (stall_prev && dma_tvalid) check("stall_hold", dma_tdata, held);
        if (dma_tvalid && dma_tready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_beat: got data %h, required no beat", dma_tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", dma_tdata, e.data);
            check("beat_keep_last", {223'h0, dma_tkeep, dma_tlast}, {223'h0, e.keep, e.last});
          end
        end
        stall_prev = dma_tvalid & ~dma_tready;
        held = dma_tdata;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    n_vec++; n_err++;
    $display("FAIL watchdog: got simulation still running, required completion");
    finish_run();
  end

  initial begin
    beat_t b;
    logic [255:0] d;
    logic [31:0]  k;
    mix_q = {32'h0000_0000, 32'h0000_005A, 32'h0000_1234, 32'hDEAD_BEEF};

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check_bit("rst_dma_tvalid", dma_tvalid, 1'b0);
    check_bit("rst_dma_tlast", dma_tlast, 1'b0);
    check_bit("rst_axis_tready", axis_tready, 1'b0);
    check_bit("rst_trunc_err", trunc_err, 1'b0);
    check("rst_dma_tdata", dma_tdata, 256'h0);
    check("rst_dma_tkeep", {224'h0, dma_tkeep}, 256'h0);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // Bypass frame of 24 beats
    for (int i = 0; i < 24; i++) begin
      d = rand256();
      k = $urandom;
      b.data = d; b.keep = k; b.last = (i == 23);
      exp_q.push_back(b);
      send_beat(d, k, (i == 23), (i == 0) ? 1'b0 : rnd_bit());
      if (i == 0) check_bit("bypass_latency", dma_tvalid, 1'b1);
    end
    wait_drain();
    check_bit("bypass_trunc_err", trunc_err, 1'b0);

    // All-zero body
    start_frame();
    for (int g = 0; g < 47; g++) add_group(16'h0000, 256'h0);
    push_comp();
    send_comp(0, 1000);
    wait_drain();
    check_bit("zero_trunc_err", trunc_err, 1'b0);

    // Raw groups, 272 bits each
    start_frame();
    for (int g = 0; g < 47; g++) add_group(16'hFFFF, rand256());
    push_comp();
    send_comp(0, 1000);
    wait_drain();
    check_bit("raw_trunc_err", trunc_err, 1'b0);

    // Mixed codes under toggling backpressure, with one trailing padding beat
    bp_mode = 1'b1;
    start_frame();
    for (int g = 0; g < 47; g++) add_group(16'h1B1B, {mix_q, mix_q});
    check("mixed_glen_total", 256'(body_pos), 256'(47 * 128));
    push_comp();
    send_comp(1, 1000);
    wait_drain();
    bp_mode = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // Truncated body: only 10 groups of bits
    start_frame();
    for (int g = 0; g < 10; g++) add_group(16'h1B1B, {mix_q, mix_q});
    push_comp();
    send_comp(0, 1000);
    wait_drain();
    check_bit("trunc_err_set", trunc_err, 1'b1);

    // Short compressed frame ending inside the header clears the error
    b.data = rand256(); b.keep = $urandom; b.last = 1'b0;
    exp_q.push_back(b);
    send_beat(b.data, b.keep, 1'b0, 1'b1);
    check_bit("trunc_err_clear", trunc_err, 1'b0);
    b.data = rand256(); b.keep = $urandom; b.last = 1'b1;
    exp_q.push_back(b);
    send_beat(b.data, b.keep, 1'b1, 1'b0);
    wait_drain();

    // Reset in the middle of a compressed body
    mon_en = 1'b0;
    start_frame();
    for (int g = 0; g < 47; g++) add_group(16'h1B1B, {mix_q, mix_q});
    send_comp(0, 2);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    check_bit("midrst_dma_tvalid", dma_tvalid, 1'b0);
    check_bit("midrst_axis_tready", axis_tready, 1'b0);
    exp_q.delete();
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // Clean decode after reset
    start_frame();
    for (int g = 0; g < 47; g++) add_group(16'h1B1B, {mix_q, mix_q});
    push_comp();
    send_comp(0, 1000);
    wait_drain();
    check_bit("post_rst_trunc_err", trunc_err, 1'b0);

    finish_run();
  end

endmodule
